// File: rtl/bpfvm_buf_ctrl.sv
// bpfvm_buf_ctrl
// Packet buffer ring controller for a BPF filter engine. Ingress packets are
// written word by word into a ring of NUM_BUFS packet buffers. A small filter
// FSM hands each committed buffer to the CPU in ring order and then reports
// the verdict downstream. The buffer is released once that verdict is taken.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_data/valid/last    ingress beat stream; in_ready back-pressure
//   mem_wr_*              registered packet memory write port (word address)
//   cpu_start/buf/len     one-cycle start pulse with the selected buffer
//   cpu_done/accept       filter finished and its verdict
//   verdict_*             verdict stream (valid/ready) with length and trunc flag
module bpfvm_buf_ctrl #(
  parameter int NUM_BUFS               = 2,
  parameter int DATA_WIDTH             = 32,
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  localparam int BSW     = (NUM_BUFS > 2) ? $clog2(NUM_BUFS) : 1,
  localparam int BPW     = DATA_WIDTH / 8,
  localparam int BPW_LOG = $clog2(BPW),
  localparam int AW      = PACKET_BYTE_ADDR_WIDTH - BPW_LOG,
  localparam int LW      = PACKET_BYTE_ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_wr_en,
  output logic [BSW-1:0]        mem_wr_buf,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  cpu_start,
  output logic [BSW-1:0]        cpu_buf,
  output logic [LW-1:0]         cpu_len,
  input  logic                  cpu_done,
  input  logic                  cpu_accept,
  output logic                  verdict_valid,
  output logic                  verdict_accept,
  output logic                  verdict_trunc,
  output logic [LW-1:0]         verdict_len,
  input  logic                  verdict_ready
);

  localparam int OW = $clog2(NUM_BUFS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REPORT} state_t;

  state_t                state_q, state_d;
  logic [BSW-1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [AW:0]           wc_q, wc_d;
  logic                  trunc_pend_q, trunc_pend_d;
  logic [LW-1:0]         len_q [NUM_BUFS];
  logic [LW-1:0]         len_d [NUM_BUFS];
  logic [NUM_BUFS-1:0]   trunc_q, trunc_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [BSW-1:0]        mem_wr_buf_q, mem_wr_buf_d;
  logic [AW-1:0]         mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  cpu_start_q, cpu_start_d;
  logic [BSW-1:0]        cpu_buf_q, cpu_buf_d;
  logic [LW-1:0]         cpu_len_q, cpu_len_d;
  logic                  verdict_valid_q, verdict_valid_d;
  logic                  verdict_accept_q, verdict_accept_d;
  logic                  verdict_trunc_q, verdict_trunc_d;
  logic [LW-1:0]         verdict_len_q, verdict_len_d;

  logic                  beat, commit, rel_buf, wc_full, commit_trunc;
  logic [AW:0]           commit_words;
  logic [LW-1:0]         commit_len;

  function automatic logic [BSW-1:0] ptr_inc(input logic [BSW-1:0] p);
    return (p == BSW'(NUM_BUFS - 1)) ? '0 : p + BSW'(1);
  endfunction

  assign in_ready = !rst && (occ_q < OW'(NUM_BUFS));
  assign beat     = in_valid && in_ready;
  assign commit   = beat && in_last;
  // wc saturates at 2^AW, so its top bit alone marks a full buffer
  assign wc_full  = wc_q[AW];

  // Length includes the final beat only if that beat still fit in the buffer
  assign commit_words = wc_q + (AW + 1)'(!wc_full);
  assign commit_len   = LW'(commit_words) << BPW_LOG;
  assign commit_trunc = trunc_pend_q || wc_full;

  // Ingress: word counter, write port and ring write pointer
  always_comb begin
    wp_d          = wp_q;
    wc_d          = wc_q;
    trunc_pend_d  = trunc_pend_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_buf_d  = mem_wr_buf_q;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    if (beat) begin
      if (!wc_full) begin
        mem_wr_en_d   = 1'b1;
        mem_wr_buf_d  = wp_q;
        mem_wr_addr_d = wc_q[AW-1:0];
        mem_wr_data_d = in_data;
        wc_d          = wc_q + (AW + 1)'(1);
      end else begin
        trunc_pend_d = 1'b1;
      end
      if (in_last) begin
        wc_d         = '0;
        trunc_pend_d = 1'b0;
        wp_d         = ptr_inc(wp_q);
      end
    end
  end

  // Per-buffer length and truncation records, written on commit
  for (genvar gi = 0; gi < NUM_BUFS; gi++) begin : g_buf
    assign len_d[gi]   = (commit && wp_q == BSW'(gi)) ? commit_len : len_q[gi];
    assign trunc_d[gi] = (commit && wp_q == BSW'(gi)) ? commit_trunc : trunc_q[gi];
  end

  // Commit and release in the same cycle cancel out
  always_comb begin
    occ_d = occ_q;
    case ({commit, rel_buf})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Filter FSM
  always_comb begin
    state_d          = state_q;
    rp_d             = rp_q;
    rel_buf          = 1'b0;
    cpu_start_d      = 1'b0;
    cpu_buf_d        = cpu_buf_q;
    cpu_len_d        = cpu_len_q;
    verdict_valid_d  = verdict_valid_q;
    verdict_accept_d = verdict_accept_q;
    verdict_trunc_d  = verdict_trunc_q;
    verdict_len_d    = verdict_len_q;
    case (state_q)
      ST_IDLE: begin
        if (occ_q != '0) begin
          cpu_start_d = 1'b1;
          cpu_buf_d   = rp_q;
          cpu_len_d   = len_q[rp_q];
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        // A done that coincides with the start pulse belongs to no packet
        if (cpu_done && !cpu_start_q) begin
          verdict_valid_d  = 1'b1;
          verdict_accept_d = cpu_accept;
          verdict_len_d    = len_q[rp_q];
          verdict_trunc_d  = trunc_q[rp_q];
          state_d          = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (verdict_ready) begin
          verdict_valid_d = 1'b0;
          rel_buf         = 1'b1;
          rp_d            = ptr_inc(rp_q);
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      wp_q             <= '0;
      rp_q             <= '0;
      occ_q            <= '0;
      wc_q             <= '0;
      trunc_pend_q     <= 1'b0;
      trunc_q          <= '0;
      mem_wr_en_q      <= 1'b0;
      mem_wr_buf_q     <= '0;
      mem_wr_addr_q    <= '0;
      mem_wr_data_q    <= '0;
      cpu_start_q      <= 1'b0;
      cpu_buf_q        <= '0;
      cpu_len_q        <= '0;
      verdict_valid_q  <= 1'b0;
      verdict_accept_q <= 1'b0;
      verdict_trunc_q  <= 1'b0;
      verdict_len_q    <= '0;
      for (int i = 0; i < NUM_BUFS; i++) len_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      wp_q             <= wp_d;
      rp_q             <= rp_d;
      occ_q            <= occ_d;
      wc_q             <= wc_d;
      trunc_pend_q     <= trunc_pend_d;
      trunc_q          <= trunc_d;
      mem_wr_en_q      <= mem_wr_en_d;
      mem_wr_buf_q     <= mem_wr_buf_d;
      mem_wr_addr_q    <= mem_wr_addr_d;
      mem_wr_data_q    <= mem_wr_data_d;
      cpu_start_q      <= cpu_start_d;
      cpu_buf_q        <= cpu_buf_d;
      cpu_len_q        <= cpu_len_d;
      verdict_valid_q  <= verdict_valid_d;
      verdict_accept_q <= verdict_accept_d;
      verdict_trunc_q  <= verdict_trunc_d;
      verdict_len_q    <= verdict_len_d;
      for (int i = 0; i < NUM_BUFS; i++) len_q[i] <= len_d[i];
    end
  end

  assign mem_wr_en      = mem_wr_en_q;
  assign mem_wr_buf     = mem_wr_buf_q;
  assign mem_wr_addr    = mem_wr_addr_q;
  assign mem_wr_data    = mem_wr_data_q;
  assign cpu_start      = cpu_start_q;
  assign cpu_buf        = cpu_buf_q;
  assign cpu_len        = cpu_len_q;
  assign verdict_valid  = verdict_valid_q;
  assign verdict_accept = verdict_accept_q;
  assign verdict_trunc  = verdict_trunc_q;
  assign verdict_len    = verdict_len_q;

endmodule

// File: tb/tb_bpfvm_buf_ctrl.sv
// Testbench for bpfvm_buf_ctrl: three buffers of four 32-bit words, so short
// packets exercise truncation and ring wrap. Expected writes, starts and
// verdicts are queued as stimulus is issued; a monitor compares on output.
module tb_bpfvm_buf_ctrl;
  localparam int NB = 3;
  localparam int DW = 32;
  localparam int PB = 4;
  localparam int BSW = 2;
  localparam int AW = 2;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic          mem_wr_en;
  logic [BSW-1:0] mem_wr_buf;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          cpu_start;
  logic [BSW-1:0] cpu_buf;
  logic [LW-1:0] cpu_len;
  logic          cpu_done, cpu_accept;
  logic          verdict_valid, verdict_accept, verdict_trunc, verdict_ready;
  logic [LW-1:0] verdict_len;

  always #5 clk = ~clk;

  bpfvm_buf_ctrl #(.NUM_BUFS(NB), .DATA_WIDTH(DW), .PACKET_BYTE_ADDR_WIDTH(PB)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_buf(mem_wr_buf), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .cpu_start(cpu_start), .cpu_buf(cpu_buf), .cpu_len(cpu_len),
    .cpu_done(cpu_done), .cpu_accept(cpu_accept),
    .verdict_valid(verdict_valid), .verdict_accept(verdict_accept),
    .verdict_trunc(verdict_trunc), .verdict_len(verdict_len),
    .verdict_ready(verdict_ready)
  );

  typedef struct packed {
    logic [LW-1:0] len;
    logic          trunc;
    logic          acc;
  } pkt_t;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] wr_q[$];
  logic [63:0] st_q[$];
  logic [63:0] vd_q[$];
  pkt_t        pkt_q[$];

  bit cpu_hold = 0, rsp_flush = 0, spur_req = 0, spur_acc = 0;
  bit ready_hold = 0, ready_rand = 0, gap_rand = 0;
  bit rsp_pend;
  int rsp_cnt;
  int rsp_delay = 1;

  // Seven-packet ring sequence: beats, expected buffer, length, trunc, verdict
  localparam int NBT  [7] = '{1, 3, 5, 2, 4, 6, 1};
  localparam int EBUF [7] = '{0, 1, 2, 0, 1, 2, 0};
  localparam int ELEN [7] = '{4, 12, 16, 8, 16, 16, 4};
  localparam int ETR  [7] = '{0, 0, 1, 0, 0, 1, 0};
  localparam int EACC [7] = '{1, 0, 1, 1, 0, 0, 1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT output event against the expectation queues
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_wr_en) begin
        if (wr_q.size() == 0) chk("mem_write_unexpected", 64'(1), 64'(0));
        else chk("mem_write", 64'({mem_wr_buf, mem_wr_addr, mem_wr_data}), wr_q.pop_front());
      end
      if (cpu_start) begin
        if (st_q.size() == 0) chk("cpu_start_unexpected", 64'(1), 64'(0));
        else chk("cpu_start", 64'({cpu_buf, cpu_len}), st_q.pop_front());
      end
      if (verdict_valid) begin
        if (vd_q.size() == 0) chk("verdict_unexpected", 64'(1), 64'(0));
        else begin
          chk("verdict", 64'({verdict_accept, verdict_trunc, verdict_len}), vd_q[0]);
          if (verdict_ready) void'(vd_q.pop_front());
        end
      end
    end
  end

  // CPU model: answers each start after rsp_delay cycles with the packet's verdict
  initial begin
    cpu_done = 1'b0;
    cpu_accept = 1'b0;
    rsp_pend = 1'b0;
    rsp_cnt = 0;
    forever begin
      @(negedge clk);
      cpu_done = 1'b0;
      if (rsp_flush) begin
        rsp_pend = 1'b0;
        rsp_flush = 1'b0;
      end
      if (spur_req) begin
        cpu_done = 1'b1;
        cpu_accept = spur_acc;
        spur_req = 1'b0;
      end else if (cpu_start && !rst) begin
        rsp_pend = 1'b1;
        rsp_cnt = rsp_delay;
      end else if (rsp_pend && !cpu_hold) begin
        if (rsp_cnt > 0) rsp_cnt--;
        else begin
          rsp_pend = 1'b0;
          if (pkt_q.size() == 0) chk("cpu_model_no_packet", 64'(1), 64'(0));
          else begin
            pkt_t p;
            p = pkt_q.pop_front();
            cpu_done = 1'b1;
            cpu_accept = p.acc;
            vd_q.push_back(64'({p.acc, p.trunc, p.len}));
          end
        end
      end
    end
  end

  // Verdict consumer
  initial begin
    verdict_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      verdict_ready = ready_hold ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    if (gap_rand) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_pkt(input int nb, input logic [DW-1:0] base, input int ebuf,
                          input int elen, input int etr, input int acc);
    for (int i = 0; i < nb; i++)
      if (i < 4) wr_q.push_back(64'({BSW'(ebuf), AW'(i), base + DW'(i)}));
    st_q.push_back(64'({BSW'(ebuf), LW'(elen)}));
    pkt_q.push_back('{len: LW'(elen), trunc: 1'(etr), acc: 1'(acc)});
    for (int i = 0; i < nb; i++) send_beat(base + DW'(i), i == nb - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rsp_flush = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    wr_q.delete();
    st_q.delete();
    vd_q.delete();
    pkt_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_outputs", 64'({mem_wr_en, cpu_start, verdict_valid, cpu_buf, cpu_len, verdict_len}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((wr_q.size() + st_q.size() + vd_q.size() + pkt_q.size() != 0 || verdict_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(wr_q.size() + st_q.size() + vd_q.size() + pkt_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_verdict();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!verdict_valid && n < 50);
    chk("verdict_wait", 64'(verdict_valid), 64'(1));
  endtask

  initial begin
    in_data = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    do_reset();
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Spurious done while idle must not produce anything
    spur_acc = 1'b1;
    spur_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("spur_idle_no_verdict", 64'(verdict_valid), 64'(0));
    @(posedge clk);
    #1;

    // Single 3-word packet
    send_pkt(3, 32'hA0A0_0000, 0, 12, 0, 1);
    drain("t1_drain");

    // Truncated 6-beat packet then a short one
    send_pkt(6, 32'hB000_0000, 1, 16, 1, 0);
    send_pkt(2, 32'hC000_0000, 2, 8, 0, 1);
    drain("t2_drain");

    // Fill the ring with the filter stalled, then hold the verdict
    cpu_hold = 1'b1;
    ready_hold = 1'b1;
    send_pkt(1, 32'hD000_0000, 0, 4, 0, 1);
    send_pkt(1, 32'hD100_0000, 1, 4, 0, 0);
    send_pkt(1, 32'hD200_0000, 2, 4, 0, 1);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    cpu_hold = 1'b0;
    wait_verdict();
    spur_acc = 1'b0;
    spur_req = 1'b1;
    repeat (5) begin
      chk("hold_valid", 64'(verdict_valid), 64'(1));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    ready_hold = 1'b0;
    @(negedge clk);
    chk("pre_release_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("post_release_in_ready", 64'(in_ready), 64'(1));
    drain("t3_drain");

    // Seven packets with random backpressure on both sides
    ready_rand = 1'b1;
    gap_rand = 1'b1;
    rsp_delay = 3;
    for (int i = 0; i < 7; i++)
      send_pkt(NBT[i], DW'(i) << 8, EBUF[i], ELEN[i], ETR[i], EACC[i]);
    drain("t4_drain");
    ready_rand = 1'b0;
    gap_rand = 1'b0;
    rsp_delay = 1;

    // Reset in the middle of the third packet
    cpu_hold = 1'b1;
    send_pkt(1, 32'hE000_0000, 1, 4, 0, 1);
    send_pkt(2, 32'hE100_0000, 2, 8, 0, 0);
    wr_q.push_back(64'({2'd0, 2'd0, 32'hE200_0000}));
    wr_q.push_back(64'({2'd0, 2'd1, 32'hE200_0001}));
    send_beat(32'hE200_0000, 1'b0);
    send_beat(32'hE200_0001, 1'b0);
    do_reset();
    cpu_hold = 1'b0;
    @(negedge clk);
    chk("in_ready_after_mid_rst", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    send_pkt(2, 32'hF000_0000, 0, 8, 0, 1);
    send_pkt(5, 32'hF100_0000, 1, 16, 1, 0);
    drain("t5_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
